// File: rtl/rename_unit.sv
// rtl/rename_unit.sv - register rename stage: speculative/architectural RATs, bit-vector free list
module rename_unit #(
    parameter int NUM_PREGS     = 64,
    parameter int PREG_ADDR_LEN = 6
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    input  logic [4:0]               rd_i,
    input  logic                     rd_we_i,
    input  logic [31:0]              pc_i,
    input  logic [31:0]              inst_i,
    input  logic                     rob_full_i,
    output logic                     out_valid_o,
    output logic [31:0]              pc_o,
    output logic [31:0]              inst_o,
    output logic [PREG_ADDR_LEN-1:0] prs1_o,
    output logic [PREG_ADDR_LEN-1:0] prs2_o,
    output logic [PREG_ADDR_LEN-1:0] prd_o,
    output logic [PREG_ADDR_LEN-1:0] old_prd_o,
    output logic                     rd_we_o,
    input  logic                     commit_valid_i,
    input  logic                     commit_rd_we_i,
    input  logic [4:0]               commit_rd_i,
    input  logic [PREG_ADDR_LEN-1:0] commit_prd_i,
    input  logic [PREG_ADDR_LEN-1:0] commit_old_prd_i,
    input  logic                     flush_i,
    output logic [PREG_ADDR_LEN:0]   free_count_o
);
    localparam int NUM_AREGS = 32;
    localparam logic [NUM_PREGS-1:0] FREE_RESET = {{(NUM_PREGS-NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
    localparam logic [PREG_ADDR_LEN:0] COUNT_RESET = (PREG_ADDR_LEN+1)'(NUM_PREGS - NUM_AREGS);

    logic [PREG_ADDR_LEN-1:0] spec_rat [NUM_AREGS];
    logic [PREG_ADDR_LEN-1:0] arch_rat [NUM_AREGS];
    logic [PREG_ADDR_LEN-1:0] arch_rat_next [NUM_AREGS];
    logic [NUM_PREGS-1:0]     free_q;
    logic [NUM_PREGS-1:0]     free_d;
    logic [NUM_PREGS-1:0]     flush_free;
    logic [PREG_ADDR_LEN:0]   free_count_q;
    logic [PREG_ADDR_LEN-1:0] alloc_idx;
    logic                     accept;
    logic                     alloc;
    logic                     commit_en;
    logic                     commit_free;

    assign in_ready_o   = !flush_i && !rob_full_i && (free_count_q != '0);
    assign accept       = in_valid_i && in_ready_o;
    assign alloc        = accept && rd_we_i && (rd_i != 5'd0);
    assign commit_en    = commit_valid_i && commit_rd_we_i && (commit_rd_i != 5'd0);
    // Freeing preg 0 or an already-free preg is ignored so the count stays consistent.
    assign commit_free  = commit_en && (commit_old_prd_i != '0) && !free_q[commit_old_prd_i];
    assign free_count_o = free_count_q;

    always_comb begin
        alloc_idx = '0;
        for (int p = NUM_PREGS - 1; p >= 0; p--) begin
            if (free_q[p]) alloc_idx = PREG_ADDR_LEN'(p);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_AREGS; i++) arch_rat_next[i] = arch_rat[i];
        if (commit_en) arch_rat_next[commit_rd_i] = commit_prd_i;
    end

    always_comb begin
        flush_free = '1;
        for (int i = 0; i < NUM_AREGS; i++) flush_free[arch_rat_next[i]] = 1'b0;
    end

    // Allocation uses the pre-edge free vector, so a preg freed this cycle is not handed out.
    always_comb begin
        free_d = free_q;
        if (alloc) free_d[alloc_idx] = 1'b0;
        if (commit_free) free_d[commit_old_prd_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                spec_rat[i] <= PREG_ADDR_LEN'(i);
                arch_rat[i] <= PREG_ADDR_LEN'(i);
            end
            free_q       <= FREE_RESET;
            free_count_q <= COUNT_RESET;
            out_valid_o  <= 1'b0;
            pc_o         <= '0;
            inst_o       <= '0;
            prs1_o       <= '0;
            prs2_o       <= '0;
            prd_o        <= '0;
            old_prd_o    <= '0;
            rd_we_o      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_AREGS; i++) arch_rat[i] <= arch_rat_next[i];
            out_valid_o <= accept;
            if (flush_i) begin
                for (int i = 0; i < NUM_AREGS; i++) spec_rat[i] <= arch_rat_next[i];
                free_q       <= flush_free;
                free_count_q <= COUNT_RESET;
            end else begin
                free_q <= free_d;
                case ({commit_free, alloc})
                    2'b10:   free_count_q <= free_count_q + 1'b1;
                    2'b01:   free_count_q <= free_count_q - 1'b1;
                    default: free_count_q <= free_count_q;
                endcase
                if (alloc) spec_rat[rd_i] <= alloc_idx;
            end
            if (accept) begin
                pc_o      <= pc_i;
                inst_o    <= inst_i;
                prs1_o    <= spec_rat[rs1_i];
                prs2_o    <= spec_rat[rs2_i];
                prd_o     <= alloc ? alloc_idx : '0;
                old_prd_o <= alloc ? spec_rat[rd_i] : '0;
                rd_we_o   <= alloc;
            end
        end
    end
endmodule

// File: tb/tb_rename_unit.sv
// tb/tb_rename_unit.sv - table-driven directed bench for rename_unit
module tb_rename_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        rd_we = 1'b0;
    logic [31:0] pc = '0, inst = '0;
    logic        rob_full = 1'b0;
    logic        out_valid;
    logic [31:0] pc_out, inst_out;
    logic [5:0]  prs1, prs2, prd, old_prd;
    logic        rd_we_out;
    logic        commit_valid = 1'b0, commit_rd_we = 1'b0;
    logic [4:0]  commit_rd = '0;
    logic [5:0]  commit_prd = '0, commit_old_prd = '0;
    logic        flush = 1'b0;
    logic [6:0]  free_count;

    int n_checks = 0;
    int n_fail = 0;

    rename_unit #(.NUM_PREGS(64), .PREG_ADDR_LEN(6)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .rd_we_i(rd_we),
        .pc_i(pc), .inst_i(inst), .rob_full_i(rob_full),
        .out_valid_o(out_valid), .pc_o(pc_out), .inst_o(inst_out),
        .prs1_o(prs1), .prs2_o(prs2), .prd_o(prd), .old_prd_o(old_prd), .rd_we_o(rd_we_out),
        .commit_valid_i(commit_valid), .commit_rd_we_i(commit_rd_we), .commit_rd_i(commit_rd),
        .commit_prd_i(commit_prd), .commit_old_prd_i(commit_old_prd),
        .flush_i(flush), .free_count_o(free_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [4:0] rs1, rs2, rd;
        logic       we, robf;
        logic       cv, cwe;
        logic [4:0] crd;
        logic [5:0] cprd, cold;
        logic       fl;
        logic       e_ready, e_ov;
        logic [5:0] e_prs1, e_prs2, e_prd, e_old;
        logic       e_we;
        logic [6:0] e_fc;
    } vec_t;

    function automatic vec_t mk(
        input logic iv, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
        input logic we, input logic robf, input logic cv, input logic cwe,
        input logic [4:0] crd, input logic [5:0] cprd, input logic [5:0] cold, input logic fl,
        input logic e_ready, input logic e_ov, input logic [5:0] e_prs1, input logic [5:0] e_prs2,
        input logic [5:0] e_prd, input logic [5:0] e_old, input logic e_we, input logic [6:0] e_fc);
        vec_t v;
        v.iv = iv; v.rs1 = r1; v.rs2 = r2; v.rd = d; v.we = we; v.robf = robf;
        v.cv = cv; v.cwe = cwe; v.crd = crd; v.cprd = cprd; v.cold = cold; v.fl = fl;
        v.e_ready = e_ready; v.e_ov = e_ov; v.e_prs1 = e_prs1; v.e_prs2 = e_prs2;
        v.e_prd = e_prd; v.e_old = e_old; v.e_we = e_we; v.e_fc = e_fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag, input logic [31:0] pc_val);
        @(negedge clk);
        in_valid = v.iv; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; rd_we = v.we; rob_full = v.robf;
        commit_valid = v.cv; commit_rd_we = v.cwe; commit_rd = v.crd;
        commit_prd = v.cprd; commit_old_prd = v.cold; flush = v.fl;
        pc = pc_val; inst = ~pc_val;
        #1 chk({tag, " in_ready"}, 32'(in_ready), 32'(v.e_ready));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v.e_ov));
        chk({tag, " free_count"}, 32'(free_count), 32'(v.e_fc));
        if (v.e_ov) begin
            chk({tag, " prs1"}, 32'(prs1), 32'(v.e_prs1));
            chk({tag, " prs2"}, 32'(prs2), 32'(v.e_prs2));
            chk({tag, " prd"}, 32'(prd), 32'(v.e_prd));
            chk({tag, " old_prd"}, 32'(old_prd), 32'(v.e_old));
            chk({tag, " rd_we_o"}, 32'(rd_we_out), 32'(v.e_we));
            chk({tag, " pc_o"}, pc_out, pc_val);
            chk({tag, " inst_o"}, inst_out, ~pc_val);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; in_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0; rob_full = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    vec_t tbl [12];

    initial begin
        //          iv rs1 rs2 rd we rf cv cwe crd cprd cold fl | rdy ov prs1 prs2 prd old we fc
        tbl[0]  = mk(1, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1,  5,  0, 32,  5, 1, 31);
        tbl[1]  = mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1,  0, 32,  0,  0, 0, 31);
        tbl[2]  = mk(1, 5, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 32, 32, 33, 32, 1, 30);
        tbl[3]  = mk(1, 7, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1,  7,  3,  0,  0, 0, 30);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0,  0,  0,  0,  0, 0, 30);
        tbl[5]  = mk(1, 5, 0, 6, 1, 0, 1, 1, 5, 32, 5, 0,  1, 1, 33,  0, 34,  6, 1, 30);
        tbl[6]  = mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1,  0,  0,  5,  8, 1, 29);
        tbl[7]  = mk(1, 1, 1, 1, 1, 0, 1, 1, 5, 33, 32, 1, 0, 0,  0,  0,  0,  0, 0, 32);
        tbl[8]  = mk(1, 5, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 33,  8,  5,  1, 1, 31);
        tbl[9]  = mk(1, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1,  5,  0, 32,  2, 1, 30);
        tbl[10] = mk(1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0,  0,  0,  0,  0, 0, 30);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 40, 0,  1, 0,  0,  0,  0,  0, 0, 30);

        do_reset();
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset free_count", 32'(free_count), 32'd32);
        chk("reset prd", 32'(prd), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++)
            step(tbl[i], $sformatf("vec%0d", i), 32'h1000 + 32'(i) * 4);

        // Exhaust the free list, stall, then a commit reopens exactly one preg.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            logic [4:0] d;
            logic [5:0] o;
            d = 5'((i % 31) + 1);
            o = (i == 31) ? 6'd32 : 6'(d);
            step(mk(1, 0, 0, d, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6'(32 + i), o, 1, 7'(31 - i)),
                 $sformatf("fill%0d", i), 32'h2000 + 32'(i));
        end
        step(mk(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "stall0", 32'h3000);
        step(mk(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "stall1", 32'h3000);
        step(mk(1, 0, 0, 4, 1, 0, 1, 1, 5, 36, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1), "commit5", 32'h3000);
        step(mk(1, 5, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 36, 0, 5, 41, 1, 0), "realloc5", 32'h3004);

        // Rename x3 twice, commit the first, then flush back to architectural state.
        do_reset();
        step(mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32, 3, 1, 31), "x3a", 32'h4000);
        step(mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 33, 32, 1, 30), "x3b", 32'h4004);
        step(mk(0, 0, 0, 0, 0, 0, 1, 1, 3, 32, 3, 0, 1, 0, 0, 0, 0, 0, 0, 31), "commit3", 32'h4008);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32), "flush", 32'h400c);
        step(mk(1, 3, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32, 0, 3, 9, 1, 31), "postflush", 32'h4010);

        // Asynchronous reset between clock edges.
        #2 reset_n = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async prd", 32'(prd), 32'd0);
        chk("async pc_o", pc_out, 32'd0);
        chk("async free_count", 32'(free_count), 32'd32);
        @(negedge clk);
        reset_n = 1'b1;
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
